// File: rtl/fas_round_stage.sv
// Rounding stage for the FP add/sub pipeline: keeps the top OUT_W significand bits,
// rounds them per transaction in the selected IEEE-754 mode, and handles carry-out and overflow.
module fas_round_stage #(
  parameter int SIG_W   = 32,
  parameter int OUT_W   = 24,
  parameter int EXP_W   = 9,
  parameter int EXP_MAX = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [SIG_W:0]   x_in,
  input  logic [EXP_W-1:0] e_in,
  input  logic [2:0]       rmode,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [OUT_W:0]   x_out,
  output logic [EXP_W-1:0] e_out,
  output logic             inexact,
  output logic             ovf,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int RND_W = SIG_W - OUT_W;

  typedef enum logic [2:0] {
    RM_RNE = 3'b000,
    RM_RTZ = 3'b001,
    RM_RDN = 3'b010,
    RM_RUP = 3'b011,
    RM_RNA = 3'b100
  } roundMode_t;

  logic             w_sign;
  logic [SIG_W-1:0] w_sig;
  logic [OUT_W-1:0] w_keep;
  logic             w_guard;
  logic             w_sticky;
  logic             w_lsb;
  logic             w_zero;
  logic             w_inc;
  logic [OUT_W:0]   w_sum;

  logic             r_vA;
  logic [OUT_W:0]   r_sumA;
  logic             r_signA;
  logic [EXP_W-1:0] r_expA;
  logic             r_inexA;
  logic             r_zeroA;

  logic             r_vB;
  logic [OUT_W:0]   r_xOut;
  logic [EXP_W-1:0] r_eOut;
  logic             r_inexB;
  logic             r_ovfB;

  logic             w_advA;
  logic             w_advB;
  logic             w_carry;
  logic [OUT_W-1:0] w_sigB;
  logic [EXP_W:0]   w_expSum;
  logic             w_ovf;

  assign w_sign   = x_in[SIG_W];
  assign w_sig    = x_in[SIG_W-1:0];
  assign w_keep   = w_sig[SIG_W-1 -: OUT_W];
  assign w_guard  = w_sig[RND_W-1];
  assign w_sticky = |w_sig[RND_W-2:0];
  assign w_lsb    = w_keep[0];
  assign w_zero   = ~|w_sig;

  // Unused encodings 101-111 fall back to round-to-nearest-even.
  always_comb begin
    w_inc = w_guard & (w_sticky | w_lsb);
    case (roundMode_t'(rmode))
      RM_RNE:  w_inc = w_guard & (w_sticky | w_lsb);
      RM_RTZ:  w_inc = 1'b0;
      RM_RDN:  w_inc = w_sign & (w_guard | w_sticky);
      RM_RUP:  w_inc = ~w_sign & (w_guard | w_sticky);
      RM_RNA:  w_inc = w_guard;
      default: w_inc = w_guard & (w_sticky | w_lsb);
    endcase
  end

  assign w_sum = {1'b0, w_keep} + {{OUT_W{1'b0}}, w_inc};

  assign w_advB   = ~r_vB | out_ready;
  assign w_advA   = ~r_vA | w_advB;
  assign in_ready = w_advA;

  // A rounding carry-out leaves 1000..0 in the upper bits; shift it down and bump the exponent.
  assign w_carry  = r_sumA[OUT_W];
  assign w_sigB   = w_carry ? r_sumA[OUT_W:1] : r_sumA[OUT_W-1:0];
  assign w_expSum = {1'b0, r_expA} + {{EXP_W{1'b0}}, w_carry};
  assign w_ovf    = ~r_zeroA & (w_expSum >= (EXP_W+1)'(EXP_MAX));

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_vA    <= 1'b0;
      r_sumA  <= '0;
      r_signA <= 1'b0;
      r_expA  <= '0;
      r_inexA <= 1'b0;
      r_zeroA <= 1'b0;
      r_vB    <= 1'b0;
      r_xOut  <= '0;
      r_eOut  <= '0;
      r_inexB <= 1'b0;
      r_ovfB  <= 1'b0;
    end else begin
      if (w_advA) begin
        r_vA <= in_valid;
        if (in_valid) begin
          r_sumA  <= w_sum;
          r_signA <= w_sign;
          r_expA  <= e_in;
          r_inexA <= w_guard | w_sticky;
          r_zeroA <= w_zero;
        end
      end
      if (w_advB) begin
        r_vB <= r_vA;
        if (r_vA) begin
          r_inexB <= r_inexA;
          r_ovfB  <= w_ovf;
          if (w_ovf) begin
            r_xOut <= {r_signA, {OUT_W{1'b0}}};
            r_eOut <= EXP_W'(EXP_MAX);
          end else begin
            r_xOut <= {r_signA, w_sigB};
            r_eOut <= w_expSum[EXP_W-1:0];
          end
        end
      end
    end
  end

  assign x_out     = r_xOut;
  assign e_out     = r_eOut;
  assign inexact   = r_inexB;
  assign ovf       = r_ovfB;
  assign out_valid = r_vB;

endmodule

// File: tb/tb_fas_round_stage.sv
// Directed testbench for fas_round_stage: rounding modes, carry, overflow,
// backpressure ordering and mid-stream reset, against hand-computed results.
module tb_fas_round_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [32:0] x_in = '0;
  logic [8:0]  e_in = '0;
  logic [2:0]  rmode = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [24:0] x_out;
  logic [8:0]  e_out;
  logic        inexact;
  logic        ovf;
  logic        out_valid;
  logic        out_ready = 1'b1;

  int nChecks = 0;
  int nFail   = 0;

  fas_round_stage dut (
    .clk(clk), .rst(rst), .x_in(x_in), .e_in(e_in), .rmode(rmode),
    .in_valid(in_valid), .in_ready(in_ready), .x_out(x_out), .e_out(e_out),
    .inexact(inexact), .ovf(ovf), .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChecks++;
    if (obs !== exp) begin
      nFail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One isolated transaction through an empty pipeline with out_ready held high.
  task automatic applyStimulus(input string tag, input logic s, input logic [31:0] sig,
                               input logic [8:0] e, input logic [2:0] m,
                               input logic [24:0] expX, input logic [8:0] expE,
                               input logic expInex, input logic expOvf);
    int lat;
    bit seen;
    @(negedge clk);
    x_in = {s, sig}; e_in = e; rmode = m; in_valid = 1'b1;
    #1;
    checkOutput($sformatf("%s.rdy", tag), 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    lat = 0; seen = 1'b0;
    for (int c = 0; c < 8 && !seen; c++) begin
      @(negedge clk);
      lat++;
      if (out_valid) seen = 1'b1;
    end
    checkOutput($sformatf("%s.lat", tag), seen ? 32'(lat) : 32'd99, 32'd2);
    checkOutput($sformatf("%s.x", tag), 32'(x_out), 32'(expX));
    checkOutput($sformatf("%s.e", tag), 32'(e_out), 32'(expE));
    checkOutput($sformatf("%s.inex", tag), 32'(inexact), 32'(expInex));
    checkOutput($sformatf("%s.ovf", tag), 32'(ovf), 32'(expOvf));
  endtask

  initial begin
    int nIn, nOut, spurious;
    logic [24:0] bpExpX [4];
    logic [8:0]  bpExpE [4];

    // Reset state
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("rst.valid", 32'(out_valid), 32'd0);
    checkOutput("rst.x", 32'(x_out), 32'd0);
    checkOutput("rst.e", 32'(e_out), 32'd0);
    checkOutput("rst.flags", {30'd0, inexact, ovf}, 32'd0);
    checkOutput("rst.rdy", 32'(in_ready), 32'd1);

    applyStimulus("rneTieEven", 1'b0, 32'h8000_0080, 9'd100, 3'b000, {1'b0, 24'h800000}, 9'd100, 1'b1, 1'b0);
    applyStimulus("rneTieOdd",  1'b0, 32'h8000_0180, 9'd100, 3'b000, {1'b0, 24'h800002}, 9'd100, 1'b1, 1'b0);
    applyStimulus("carry",      1'b0, 32'hFFFF_FF80, 9'd100, 3'b000, {1'b0, 24'h800000}, 9'd101, 1'b1, 1'b0);
    applyStimulus("rdnNeg",     1'b1, 32'h8000_0001, 9'd100, 3'b010, {1'b1, 24'h800001}, 9'd100, 1'b1, 1'b0);
    applyStimulus("rdnPos",     1'b0, 32'h8000_0001, 9'd100, 3'b010, {1'b0, 24'h800000}, 9'd100, 1'b1, 1'b0);
    applyStimulus("rupPos",     1'b0, 32'h8000_0001, 9'd100, 3'b011, {1'b0, 24'h800001}, 9'd100, 1'b1, 1'b0);
    applyStimulus("rupNeg",     1'b1, 32'h8000_0001, 9'd100, 3'b011, {1'b1, 24'h800000}, 9'd100, 1'b1, 1'b0);
    applyStimulus("rtz",        1'b0, 32'h8000_0001, 9'd100, 3'b001, {1'b0, 24'h800000}, 9'd100, 1'b1, 1'b0);
    applyStimulus("rnaTie",     1'b0, 32'h8000_0080, 9'd100, 3'b100, {1'b0, 24'h800001}, 9'd100, 1'b1, 1'b0);
    applyStimulus("exact",      1'b0, 32'h8000_0000, 9'd100, 3'b011, {1'b0, 24'h800000}, 9'd100, 1'b0, 1'b0);
    applyStimulus("mode7",      1'b0, 32'h8000_0180, 9'd100, 3'b111, {1'b0, 24'h800002}, 9'd100, 1'b1, 1'b0);
    applyStimulus("ovfRup",     1'b0, 32'hFFFF_FFFF, 9'd254, 3'b011, {1'b0, 24'h000000}, 9'd255, 1'b1, 1'b1);
    applyStimulus("noOvfRtz",   1'b0, 32'hFFFF_FFFF, 9'd254, 3'b001, {1'b0, 24'hFFFFFF}, 9'd254, 1'b1, 1'b0);
    applyStimulus("zero",       1'b1, 32'h0000_0000, 9'd77,  3'b011, {1'b1, 24'h000000}, 9'd77,  1'b0, 1'b0);

    // Backpressure: four back-to-back inputs, out_ready low for cycles 0-5
    for (int i = 0; i < 4; i++) begin
      bpExpX[i] = {1'b0, 24'h800000 + 24'(i)};
      bpExpE[i] = 9'(10 + i);
    end
    nIn = 0; nOut = 0;
    for (int cyc = 0; cyc < 40 && nOut < 4; cyc++) begin
      @(negedge clk);
      out_ready = (cyc >= 6);
      in_valid  = (nIn < 4);
      x_in      = {1'b0, 32'h8000_0000 | (32'(nIn) << 8)};
      e_in      = 9'(10 + nIn);
      rmode     = 3'b001;
      #1;
      if (cyc >= 2 && cyc <= 5) begin
        checkOutput($sformatf("bp.rdyLow%0d", cyc), 32'(in_ready), 32'd0);
        checkOutput($sformatf("bp.hold%0d", cyc), {6'd0, out_valid, x_out}, {7'd1, bpExpX[0]});
      end
      if (in_valid && in_ready) nIn++;
      if (out_valid && out_ready) begin
        checkOutput($sformatf("bp.x%0d", nOut), 32'(x_out), 32'(bpExpX[nOut]));
        checkOutput($sformatf("bp.e%0d", nOut), 32'(e_out), 32'(bpExpE[nOut]));
        nOut++;
      end
    end
    in_valid = 1'b0;
    checkOutput("bp.count", 32'(nOut), 32'd4);

    // Reset with two transactions in flight
    @(negedge clk);
    out_ready = 1'b0;
    x_in = {1'b1, 32'hC000_0000}; e_in = 9'd50; rmode = 3'b000; in_valid = 1'b1;
    @(negedge clk);
    x_in = {1'b0, 32'hA000_0000}; e_in = 9'd60;
    @(negedge clk);
    in_valid = 1'b0;
    checkOutput("mid.preValid", 32'(out_valid), 32'd1);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    checkOutput("mid.valid", 32'(out_valid), 32'd0);
    checkOutput("mid.x", 32'(x_out), 32'd0);
    checkOutput("mid.e", 32'(e_out), 32'd0);
    checkOutput("mid.flags", {30'd0, inexact, ovf}, 32'd0);
    checkOutput("mid.rdy", 32'(in_ready), 32'd1);
    out_ready = 1'b1;
    spurious = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (out_valid) spurious++;
    end
    checkOutput("mid.noGhost", 32'(spurious), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nChecks, nFail);
    $finish;
  end

endmodule
